// File: rtl/sap_mux_pkg.sv
// Shared types and the round-robin search helper
// for the registered channel selector.
package sap_mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  localparam int MAX_CH = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  // First valid channel after last, wrapping at n.
  function automatic rr_pick_t rr_pick(
    input logic [MAX_CH-1:0] valid,
    input int unsigned       last,
    input int unsigned       n
  );
    rr_pick_t    r;
    int unsigned k;
    r = '0;
    for (int unsigned i = 1; i <= MAX_CH; i++) begin
      k = last + i;
      if (k >= n) k = k - n;
      if (!r.found && i <= n && valid[k[4:0]]) begin
        r.found = 1'b1;
        r.idx   = k[4:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid
// channel strictly after the last granted one.
module rr_arbiter
  import sap_mux_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [SEL_W-1:0]  last,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  rr_pick_t pick;

  assign pick  = rr_pick(MAX_CH'(valid), 32'(last),
                         NUM_CH);
  assign found = pick.found;
  assign idx   = SEL_W'(pick.idx);

endmodule

// File: rtl/mux_arb_reg.sv
// Registered N-channel selector with manual or
// round-robin selection and a valid/ready output.
module mux_arb_reg
  import sap_mux_pkg::*;
#(
  parameter  int WIDTH  = 4,
  parameter  int NUM_CH = 2,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic [NUM_CH*WIDTH-1:0] D,
  input  logic [NUM_CH-1:0]       V,
  output logic [NUM_CH-1:0]       G,
  input  logic                    E,
  input  logic                    M,
  input  logic [SEL_W-1:0]        S,
  output logic [WIDTH-1:0]        Y,
  output logic                    YV,
  input  logic                    YR
);

  localparam int NPAD = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST_RST =
    SEL_W'(NUM_CH - 1);

  out_state_e       state;
  logic [SEL_W-1:0] last;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_nxt;
  logic [NPAD-1:0]  v_pad;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] gnt_idx;
  logic             rr_found;
  logic             man_ok;
  logic             can_load;
  logic             gnt;
  mode_e            mode;

  assign mode     = mode_e'(M);
  assign YV       = (state == OUT_FULL);
  assign Y        = y_q;
  assign can_load = E & (~YV | YR);

  // Padding keeps V[S] defined when S names no channel.
  assign v_pad  = NPAD'(V);
  assign man_ok = (32'(S) < NUM_CH) & v_pad[S];

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr (
    .valid (V),
    .last  (last),
    .found (rr_found),
    .idx   (rr_idx)
  );

  always_comb begin
    gnt     = 1'b0;
    gnt_idx = S;
    unique case (mode)
      MODE_MANUAL: begin
        gnt     = can_load & man_ok;
        gnt_idx = S;
      end
      MODE_RR: begin
        gnt     = can_load & rr_found;
        gnt_idx = rr_idx;
      end
    endcase
  end

  always_comb begin
    G     = '0;
    y_nxt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt_idx == SEL_W'(k)) begin
        G[k]  = gnt & ~CLR;
        y_nxt = D[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= OUT_EMPTY;
      y_q   <= '0;
      last  <= LAST_RST;
    end else if (gnt) begin
      state <= OUT_FULL;
      y_q   <= y_nxt;
      last  <= gnt_idx;
    end else if (state == OUT_FULL && YR) begin
      state <= OUT_EMPTY;
    end
  end

endmodule
